// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types for the sequential restoring divider
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_datapath.sv
// rtl/divider_datapath.sv - partial remainder, quotient and divisor registers
// with one shift-and-subtract step per enabled clock.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         do_init,
  input  logic         do_step,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient_next,
  output logic [N-1:0] remainder_next
);

  logic [N:0]   a_reg;
  logic [N-1:0] q_reg;
  logic [N-1:0] m_reg;

  logic [N:0]   a_shift;
  logic [N:0]   trial;
  logic [N:0]   a_next;
  logic [N-1:0] q_next;

  // A stays below M after every step, so the shifted value always fits in N+1 bits.
  always_comb begin
    a_shift = {a_reg[N-1:0], q_reg[N-1]};
    trial   = a_shift - {1'b0, m_reg};
    a_next  = a_shift;
    q_next  = {q_reg[N-2:0], 1'b0};
    if (!trial[N]) begin
      a_next = trial;
      q_next = {q_reg[N-2:0], 1'b1};
    end
  end

  assign quotient_next  = q_next;
  assign remainder_next = a_next[N-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
    end else if (do_init) begin
      a_reg <= '0;
      q_reg <= dividend;
      m_reg <= divisor;
    end else if (do_step) begin
      a_reg <= a_next;
      q_reg <= q_next;
    end
  end

endmodule

// File: rtl/divider_sequential.sv
// rtl/divider_sequential.sv - unsigned N-bit restoring divider, one quotient
// bit per clock, start/done handshake with divide-by-zero shortcut.
module divider_sequential
  import divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  div_state_t    state;
  logic [CW-1:0] count;
  logic          do_init;
  logic          do_step;
  logic [N-1:0]  quotient_next;
  logic [N-1:0]  remainder_next;

  assign do_init = (state == IDLE) && start && (divisor != '0);
  assign do_step = (state == RUN);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  divider_datapath #(.N(N)) u_datapath (
    .clock          (clock),
    .reset_n        (reset_n),
    .do_init        (do_init),
    .do_step        (do_step),
    .dividend       (dividend),
    .divisor        (divisor),
    .quotient_next  (quotient_next),
    .remainder_next (remainder_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Zero divisor skips the iteration and reports saturated quotient.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              count <= CW'(N);
              state <= RUN;
            end
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient    <= quotient_next;
            remainder   <= remainder_next;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_sequential.sv
// tb/tb_divider_sequential.sv - table-driven and scoreboard bench for divider_sequential
module tb_divider_sequential;

  localparam int N     = 4;
  localparam int BOUND = 40;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } result_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vector_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  result_t exp_q[$];
  result_t mon_e;
  logic    prev_done = 1'b0;
  int      checks = 0;
  int      errors = 0;

  divider_sequential #(.N(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_exp(input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
    result_t e;
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    exp_q.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_single_pulse", int'(prev_done), 0);
        check("scoreboard_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("quotient", int'(quotient), int'(mon_e.q));
          check("remainder", int'(remainder), int'(mon_e.r));
          check("div_by_zero", int'(div_by_zero), int'(mon_e.dz));
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_done(input bit drop_on_busy, input int poke, output int cyc, output int busy_cyc);
    cyc      = 0;
    busy_cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (busy) busy_cyc++;
      if (drop_on_busy && busy) start = 1'b0;
      if (poke > 0 && cyc == poke) begin
        start    = 1'b1;
        dividend = N'(6);
        divisor  = N'(2);
      end else if (poke > 0 && cyc == poke + 1) begin
        start = 1'b0;
      end
    end while (!done && cyc < BOUND);
    check("done_seen", int'(done), 1);
  endtask

  task automatic run_div(input vector_t v, input int poke);
    int cyc;
    int busy_cyc;
    @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    push_exp(v.q, v.r, v.dz);
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    wait_done(1'b0, poke, cyc, busy_cyc);
    check("latency", cyc, (v.b == '0) ? 1 : N + 1);
    check("busy_cycles", busy_cyc, (v.b == '0) ? 0 : N);
  endtask

  task automatic check_hold(input vector_t v, input int n);
    repeat (n) begin
      @(negedge clock);
      check("hold_quotient", int'(quotient), int'(v.q));
      check("hold_remainder", int'(remainder), int'(v.r));
      check("hold_div_by_zero", int'(div_by_zero), int'(v.dz));
      check("hold_done_low", int'(done), 0);
    end
  endtask

  vector_t vec[7];
  vector_t v;
  int      cyc;
  int      bc;

  initial begin
    vec[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dz: 1'b0};
    vec[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
    vec[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, dz: 1'b0};
    vec[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
    vec[4] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1};
    vec[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
    vec[6] = '{a: 4'd7,  b: 4'd2,  q: 4'd3,  r: 4'd1, dz: 1'b0};

    #1 reset_n = 1'b0;
    @(negedge clock);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_div(vec[i], 0);
    check_hold(vec[6], 3);

    // second start during busy must be ignored
    run_div(vec[0], 2);
    check_hold(vec[0], 8);

    // start held high across DONE restarts in the first IDLE cycle
    @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    push_exp(4'd3, 4'd1, 1'b0);
    @(posedge clock);
    wait_done(1'b0, 0, cyc, bc);
    check("held_first_latency", cyc, N + 1);
    dividend = 4'd6;
    divisor  = 4'd2;
    push_exp(4'd3, 4'd0, 1'b0);
    wait_done(1'b1, 0, cyc, bc);
    check("held_restart_latency", cyc, N + 2);
    check("held_start_released", int'(start), 0);

    // reset in the middle of a division aborts it
    @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    push_exp(4'd3, 4'd1, 1'b0);
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (8) @(negedge clock);
    v = '{a: 4'd6, b: 4'd2, q: 4'd3, r: 4'd0, dz: 1'b0};
    run_div(v, 0);

    // every operand pair, back to back, against a reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        v.a = N'(a);
        v.b = N'(b);
        if (b == 0) begin
          v.q  = '1;
          v.r  = N'(a);
          v.dz = 1'b1;
        end else begin
          v.q  = N'(a / b);
          v.r  = N'(a % b);
          v.dz = 1'b0;
        end
        run_div(v, 0);
      end
    end

    repeat (4) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
